cyp_ep6_writer: RTL and testbench
=================================

CYP_EP6_WRITER -- requirements
Module: cyp_ep6_writer

Interface
REQ-001 Parameter PKT_WORDS, default 256: EP6 IN packet size in 16-bit words (512 bytes); legal range 2..1024.
REQ-002 Parameter TIMEOUT_CLKS, default 64: idle cycles before a partial packet is committed with PKTEND.
REQ-003 Port cyp_clk  in  1: the single 48 MHz clock; every register is clocked on its rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port tx_en  in  1: transfer enable (tied to sdram_init_done at top level); 0 blocks new words.
REQ-006 Port src_valid  in  1: the source offers a word.
REQ-007 Port src_data  in  16: the source word.
REQ-008 Port src_ready  out  1: word accepted this cycle (combinational).
REQ-009 Port usb_flagc  in  1: CY68013 EP6 FIFO flag; 1 = not full, 0 = full.
REQ-010 Port usb_fifoaddr  out  2: CY68013 FIFO address; constant 2'b10 (EP6).
REQ-011 Port usb_slcs  out  1: chip select; constant 0.
REQ-012 Port usb_sloe / usb_slrd  out  1 each: constant 1 (the block never reads).
REQ-013 Port usb_slwr  out  1: write strobe, active-low, registered.
REQ-014 Port usb_pktend  out  1: packet end, active-low, registered.
REQ-015 Port usb_fd_o  out  16: data driven to usb_fd, registered.
REQ-016 Port usb_fd_oe  out  1: 1 = the FPGA drives usb_fd, registered.

Function
REQ-017 States: IDLE, WRITE, PEND, COMMIT.
REQ-018 Accept: src_ready = (state==WRITE) & tx_en & src_valid & usb_flagc.
REQ-019 An accepted word appears one cycle later as usb_slwr=0 with usb_fd_o=src_data, held for exactly one cycle.
REQ-020 With continuous acceptance, usb_slwr stays low and one word is written per cycle with no bubbles.
REQ-021 usb_fd_oe is 1 in every state except IDLE.
REQ-022 usb_fd_o holds its last value when no write occurs; it is 16'hFFFF after reset.
REQ-023 Transitions:
- IDLE->WRITE when tx_en=1.
- WRITE->IDLE when tx_en=0 and wcnt==0.
- WRITE->PEND when there is no accept and wcnt!=0.
- PEND->WRITE on an accept; that word is written and the timeout counter is cleared.
- PEND->COMMIT when the timeout counter reaches TIMEOUT_CLKS-1.
- COMMIT->WRITE after one cycle.
REQ-024 wcnt (10 bits) increments on each accept and wraps to 0 after PKT_WORDS-1; a full packet is auto-committed by the FX2 and never drives PKTEND.
REQ-025 usb_pktend=0 for exactly one cycle, the cycle after COMMIT is entered; usb_slwr=1 in that cycle; wcnt clears to 0.
REQ-026 PKTEND is never issued when wcnt==0 (no zero-length packets).
REQ-027 usb_flagc=0 stalls acceptance only; the timeout counter keeps running in PEND, and wcnt is unaffected.
REQ-028 tx_en falling mid-packet stops acceptance; the partial packet is still committed by timeout.
REQ-029 src_data is ignored whenever src_ready=0.

Reset
REQ-030 rst_n low forces asynchronously:
- state=IDLE, wcnt=0, timeout counter=0.
- usb_slwr=1, usb_pktend=1, usb_fd_o=16'hFFFF, usb_fd_oe=0, src_ready=0.
REQ-031 Reset asserted mid-packet discards the partial packet; no PKTEND is issued.
REQ-032 After release, the first accept is possible no earlier than the second cyp_clk edge (IDLE->WRITE first).

Verification
REQ-033 Full packet:
- Stimulus: tx_en=1, flagc=1, 256 back-to-back words 0x0000..0x00FF.
- Required: 256 consecutive slwr-low cycles with matching fd_o, usb_pktend never low, wcnt=0 at the end.
REQ-034 Partial packet:
- Stimulus: 10 words, then src_valid=0.
- Required: after 64 idle cycles, one usb_pktend-low cycle with slwr=1; the next packet starts at wcnt=0.
REQ-035 Backpressure:
- Stimulus: flagc=0 for 5 cycles during a burst.
- Required: src_ready=0 and slwr=1 throughout; no word lost or duplicated; the sequence resumes in order.
REQ-036 Timeout restart:
- Stimulus: a word arrives at idle cycle 63.
- Required: the word is written, no PKTEND, and the timeout counter restarts.
REQ-037 Reset mid-packet:
- Stimulus: rst_n low after 100 words.
- Required: all outputs return to their reset values immediately and no PKTEND is ever issued.
REQ-038 Disable:
- Stimulus: tx_en=0 with wcnt=0.
- Required: IDLE, usb_fd_oe=0, src_ready=0, no strobes.

Source files
------------

// File: rtl/cyp_ep6_writer.sv
// CY68013 (FX2) slave-FIFO writer for endpoint EP6 IN: streams 16-bit source words
// into the FX2 FIFO and commits idle partial packets with PKTEND after a timeout.
module cyp_ep6_writer #(
  parameter int PKT_WORDS    = 256,
  parameter int TIMEOUT_CLKS = 64
) (
  input  logic        cyp_clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic        src_valid,
  input  logic [15:0] src_data,
  output logic        src_ready,
  input  logic        usb_flagc,
  output logic [1:0]  usb_fifoaddr,
  output logic        usb_slcs,
  output logic        usb_sloe,
  output logic        usb_slrd,
  output logic        usb_slwr,
  output logic        usb_pktend,
  output logic [15:0] usb_fd_o,
  output logic        usb_fd_oe
);

  localparam int             TW     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [9:0]     W_LAST = 10'(PKT_WORDS - 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, PEND, COMMIT} state_t;

  state_t        state, state_nxt;
  logic [9:0]    wcnt;
  logic [TW-1:0] tcnt;
  logic          offer;
  logic          accept;

  // A word is only taken in WRITE; an offer seen in PEND wakes the FSM so the
  // word is accepted on the following cycle instead of being committed.
  assign offer     = tx_en & src_valid & usb_flagc;
  assign accept    = (state == WRITE) & offer;
  assign src_ready = accept;

  assign usb_fifoaddr = 2'b10;
  assign usb_slcs     = 1'b0;
  assign usb_sloe     = 1'b1;
  assign usb_slrd     = 1'b1;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (tx_en) state_nxt = WRITE;
      WRITE: begin
        if (!accept) begin
          if (wcnt != 10'd0)  state_nxt = PEND;
          else if (!tx_en)    state_nxt = IDLE;
        end
      end
      PEND: begin
        if (offer)                state_nxt = WRITE;
        else if (tcnt == T_LAST)  state_nxt = COMMIT;
      end
      COMMIT: state_nxt = WRITE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see
  // pre-edge values regardless of statement order.
  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt == COMMIT)
        wcnt <= '0;
      else if (accept)
        wcnt <= (wcnt == W_LAST) ? 10'd0 : wcnt + 10'd1;

      // Timeout only advances while the FSM stays parked in PEND.
      if (state == PEND && state_nxt == PEND)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
    end
  end

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      usb_slwr   <= 1'b1;
      usb_pktend <= 1'b1;
      usb_fd_o   <= 16'hFFFF;
      usb_fd_oe  <= 1'b0;
    end else begin
      usb_slwr   <= ~accept;
      usb_pktend <= ~(state_nxt == COMMIT);
      usb_fd_oe  <= (state_nxt != IDLE);
      if (accept)
        usb_fd_o <= src_data;
    end
  end

endmodule

// File: tb/tb_cyp_ep6_writer.sv
// Self-checking bench for cyp_ep6_writer: a cycle vector table followed by
// directed multi-cycle sequences, with a write scoreboard running alongside.
module tb_cyp_ep6_writer;

  logic        cyp_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic        src_valid = 1'b0;
  logic [15:0] src_data = 16'h0000;
  logic        src_ready;
  logic        usb_flagc = 1'b1;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend;
  logic [15:0] usb_fd_o;
  logic        usb_fd_oe;

  int n_checks = 0;
  int n_fail   = 0;
  int pkt_cnt  = 0;
  int wr_cnt   = 0;
  int slwr_run = 0;
  int max_run  = 0;
  logic [15:0] exp_q[$];

  cyp_ep6_writer #(.PKT_WORDS(256), .TIMEOUT_CLKS(64)) dut (
    .cyp_clk      (cyp_clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .usb_flagc    (usb_flagc),
    .usb_fifoaddr (usb_fifoaddr),
    .usb_slcs     (usb_slcs),
    .usb_sloe     (usb_sloe),
    .usb_slrd     (usb_slrd),
    .usb_slwr     (usb_slwr),
    .usb_pktend   (usb_pktend),
    .usb_fd_o     (usb_fd_o),
    .usb_fd_oe    (usb_fd_oe)
  );

  always #10 cyp_clk = ~cyp_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word must come out on the next cycle, in order.
  always @(negedge cyp_clk) begin
    if (!usb_slwr) begin
      slwr_run++;
      wr_cnt++;
      if (slwr_run > max_run) max_run = slwr_run;
      check("sb_write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_fd_o", usb_fd_o, exp_q.pop_front());
    end else begin
      slwr_run = 0;
    end
    if (!usb_pktend) begin
      pkt_cnt++;
      check("pktend_slwr_high", usb_slwr, 1);
    end
    if (src_ready) exp_q.push_back(src_data);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge cyp_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_slwr",   usb_slwr,   1);
    check("rst_pktend", usb_pktend, 1);
    check("rst_fd_o",   usb_fd_o,   16'hFFFF);
    check("rst_fd_oe",  usb_fd_oe,  0);
    check("rst_ready",  src_ready,  0);
    tx_en = 1'b0; src_valid = 1'b0; usb_flagc = 1'b1;
    repeat (2) @(posedge cyp_clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Valid/ready source: holds each word until taken; returns just after the last accept edge.
  task automatic send_words(input int n, input logic [15:0] base);
    int sent = 0;
    int guard = 0;
    src_valid = 1'b1;
    src_data  = base;
    while (sent < n && guard < 2000) begin
      @(negedge cyp_clk);
      if (src_ready) sent++;
      @(posedge cyp_clk);
      #1;
      src_data = 16'(base + sent);
      guard++;
    end
    src_valid = 1'b0;
    src_data  = 16'hDEAD;
    check("send_all_accepted", sent, n);
  endtask

  task automatic wait_pktend(input int exp_k);
    int found = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge cyp_clk);
      if (!usb_pktend) begin
        found = k;
        break;
      end
    end
    check("pktend_cycle", found, exp_k);
    @(negedge cyp_clk);
    check("pktend_one_cycle", usb_pktend, 1);
    @(posedge cyp_clk);
    #1;
  endtask

  typedef struct {
    logic        tx, v, f;
    logic [15:0] d;
    logic        rdy, slwr, pktend, oe;
    logic [15:0] fd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int p0, w0;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h9ABC, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5678};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5678};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h9ABC, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5678};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h9ABC};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9ABC};

    @(posedge cyp_clk);
    #1;
    do_reset();
    check("const_fifoaddr", usb_fifoaddr, 2'b10);
    check("const_ctrl", {usb_slcs, usb_sloe, usb_slrd}, 3'b011);

    // Cycle table: startup, accept, stall, PEND wake-up, tx_en drop.
    for (int i = 0; i < 9; i++) begin
      tx_en = vecs[i].tx; src_valid = vecs[i].v; usb_flagc = vecs[i].f; src_data = vecs[i].d;
      @(negedge cyp_clk);
      check($sformatf("vec%0d_ready", i),  src_ready,  vecs[i].rdy);
      check($sformatf("vec%0d_slwr", i),   usb_slwr,   vecs[i].slwr);
      check($sformatf("vec%0d_pktend", i), usb_pktend, vecs[i].pktend);
      check($sformatf("vec%0d_fd_oe", i),  usb_fd_oe,  vecs[i].oe);
      check($sformatf("vec%0d_fd_o", i),   usb_fd_o,   vecs[i].fd);
      @(posedge cyp_clk);
      #1;
    end

    // Full packet: 256 back-to-back words, no PKTEND, then disable from wcnt==0.
    do_reset();
    tx_en = 1'b1;
    p0 = pkt_cnt; w0 = wr_cnt; max_run = 0;
    send_words(256, 16'h0000);
    idle(100);
    check("full_run_len", max_run, 256);
    check("full_writes", wr_cnt - w0, 256);
    check("full_no_pktend", pkt_cnt - p0, 0);
    check("full_queue_empty", exp_q.size(), 0);
    tx_en = 1'b0; src_valid = 1'b1; src_data = 16'h5555;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge cyp_clk);
      check("dis_fd_oe", usb_fd_oe, 0);
      check("dis_ready", src_ready, 0);
      check("dis_strobes", {usb_slwr, usb_pktend}, 2'b11);
      @(posedge cyp_clk);
      #1;
    end
    src_valid = 1'b0;

    // Partial packet: 10 words, commit after 64 idle cycles, next packet starts at wcnt 0.
    do_reset();
    tx_en = 1'b1;
    p0 = pkt_cnt;
    send_words(10, 16'h1000);
    wait_pktend(66);
    send_words(256, 16'h2000);
    idle(100);
    check("partial_pkt_count", pkt_cnt - p0, 1);
    check("partial_queue_empty", exp_q.size(), 0);

    // Backpressure: flagc low for 5 cycles mid-burst.
    do_reset();
    tx_en = 1'b1;
    w0 = wr_cnt;
    fork
      send_words(20, 16'h0100);
      begin
        idle(6);
        usb_flagc = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge cyp_clk);
          check("bp_ready", src_ready, 0);
          if (i > 0) check("bp_slwr", usb_slwr, 1);
          @(posedge cyp_clk);
          #1;
        end
        usb_flagc = 1'b1;
      end
    join
    idle(3);
    check("bp_writes", wr_cnt - w0, 20);
    check("bp_queue_empty", exp_q.size(), 0);

    // Timeout restart: a word offered on the last PEND cycle wins over the commit.
    do_reset();
    tx_en = 1'b1;
    p0 = pkt_cnt;
    send_words(3, 16'h0C00);
    idle(64);
    send_words(1, 16'h0D00);
    wait_pktend(66);
    check("restart_pkt_count", pkt_cnt - p0, 1);
    check("restart_queue_empty", exp_q.size(), 0);

    // Reset mid-packet after 100 words, then earliest accept after release.
    do_reset();
    tx_en = 1'b1;
    p0 = pkt_cnt;
    send_words(100, 16'h3000);
    src_valid = 1'b1;
    do_reset();
    tx_en = 1'b1; src_valid = 1'b1; src_data = 16'h4444;
    @(negedge cyp_clk);
    check("rel_first_ready", src_ready, 0);
    @(posedge cyp_clk);
    #1;
    @(negedge cyp_clk);
    check("rel_second_ready", src_ready, 1);
    @(posedge cyp_clk);
    #1;
    src_valid = 1'b0;
    wait_pktend(66);
    check("rst_mid_pkt_count", pkt_cnt - p0, 1);
    check("rst_mid_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
